// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmit emitter between two byte producers (port 0: CPU
//   stores, port 1: debug/trace). Each port owns a small byte FIFO. A round-robin
//   scheduler drains the FIFOs into the emitter's valid/ready handshake. With
//   LOCK_LINES=1 an owner keeps the grant until it sends 8'h0A, so lines from the
//   two sources never interleave. LOCK_TIMEOUT empty cycles force a release.
//
// Ports
//   clk, rst                 system clock (rising edge), async active-high reset
//   p0_data/p0_valid/p0_ready  port 0 push interface (ready = FIFO not full)
//   p1_data/p1_valid/p1_ready  port 1 push interface
//   tx_data/tx_valid/tx_ready  byte stream to the UART emitter
//   grant                    one-hot current owner, 2'b00 when idle
//   p0_level/p1_level        FIFO occupancy per port
module uart_tx_arbiter #(
  parameter int DEPTH        = 4,
  parameter int LOCK_LINES   = 1,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             p0_data,
  input  logic                   p0_valid,
  output logic                   p0_ready,
  input  logic [7:0]             p1_data,
  input  logic                   p1_valid,
  output logic                   p1_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [1:0]             grant,
  output logic [$clog2(DEPTH):0] p0_level,
  output logic [$clog2(DEPTH):0] p1_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(LOCK_TIMEOUT);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  // Per-port FIFO storage; index 0 = port 0, index 1 = port 1.
  logic [7:0]    mem   [2][DEPTH];
  logic [AW-1:0] wptr  [2];
  logic [AW-1:0] rptr  [2];
  logic [LW-1:0] level [2];
  logic [7:0]    in_data [2];
  logic [1:0]    in_valid;
  logic [1:0]    can_push;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    nonempty;

  state_t        state, state_nx;
  logic          owner, owner_nx;
  logic          last, last_nx;
  logic [CW-1:0] idle_cnt, idle_cnt_nx;

  logic [7:0]    head;
  logic          xfer;

  assign in_data[0] = p0_data;
  assign in_data[1] = p1_data;
  assign in_valid   = {p1_valid, p0_valid};

  // A full FIFO refuses a push even when it is being popped on the same edge.
  assign can_push[0] = (level[0] != LW'(DEPTH));
  assign can_push[1] = (level[1] != LW'(DEPTH));
  assign nonempty[0] = (level[0] != '0);
  assign nonempty[1] = (level[1] != '0);
  assign push        = in_valid & can_push;

  assign p0_ready = can_push[0];
  assign p1_ready = can_push[1];
  assign p0_level = level[0];
  assign p1_level = level[1];

  // Offer depends only on registered state and FIFO contents, never on tx_ready.
  assign head     = mem[owner][rptr[owner]];
  assign tx_valid = (state == LOCKED) && nonempty[owner];
  assign tx_data  = tx_valid ? head : '0;
  assign grant    = (state == LOCKED) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign xfer     = tx_valid && tx_ready;
  assign pop      = xfer ? (owner ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        level[i] <= '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wptr[i]] <= in_data[i];
          wptr[i]         <= wptr[i] + 1'b1;
        end
        if (pop[i]) begin
          rptr[i] <= rptr[i] + 1'b1;
        end
        if (push[i] && !pop[i]) begin
          level[i] <= level[i] + 1'b1;
        end else if (pop[i] && !push[i]) begin
          level[i] <= level[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      idle_cnt <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      last     <= last_nx;
      idle_cnt <= idle_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    last_nx     = last;
    idle_cnt_nx = idle_cnt;
    case (state)
      IDLE: begin
        if (nonempty != 2'b00) begin
          state_nx = LOCKED;
          // Contention goes to the port that did not release last; otherwise
          // nonempty[1] alone identifies the single requester.
          owner_nx = (&nonempty) ? ~last : nonempty[1];
        end
      end
      LOCKED: begin
        if (xfer && ((LOCK_LINES == 0) || (head == 8'h0A))) begin
          state_nx    = IDLE;
          last_nx     = owner;
          idle_cnt_nx = '0;
        end else if (!nonempty[owner]) begin
          if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
            state_nx    = IDLE;
            last_nx     = owner;
            idle_cnt_nx = '0;
          end else begin
            idle_cnt_nx = idle_cnt + 1'b1;
          end
        end else begin
          idle_cnt_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Two-port arbiter that shares the single UART transmit emitter between two byte producers: port 0 for CPU stores to the UART data register, port 1 for a debug/trace source. Each port has a small byte FIFO. A round-robin, line-locking scheduler drains the FIFOs into the emitter's valid/ready handshake, so lines from the two sources never interleave on `ftdi_txd`. It sits between the SOC IO decode and the UART emitter.

## Interface
- `DEPTH`, 4: per-port FIFO depth in bytes; power of two, ≥2.
- `LOCK_LINES`, 1: 1 = the owner keeps the grant until it sends 8'h0A; 0 = the grant is released after every byte.
- `LOCK_TIMEOUT`, 1024: consecutive cycles with the owner's FIFO empty before a lock is forcibly released; ≥2.
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `p0_data` input 8: port 0 byte.
- `p0_valid` input 1: port 0 byte offered.
- `p0_ready` output 1: port 0 FIFO not full.
- `p1_data` input 8: port 1 byte.
- `p1_valid` input 1: port 1 byte offered.
- `p1_ready` output 1: port 1 FIFO not full.
- `tx_data` output 8: byte to the emitter.
- `tx_valid` output 1: byte offered to the emitter.
- `tx_ready` input 1: emitter can accept (emitter `o_ready`).
- `grant` output 2: one-hot current owner; 2'b00 when no port owns the emitter.
- `p0_level` output $clog2(DEPTH)+1: port 0 FIFO occupancy.
- `p1_level` output $clog2(DEPTH)+1: port 1 FIFO occupancy.

## Operation
- **Push.** Port n accepts a byte at a rising edge when `pn_valid && pn_ready`. `pn_ready = (pn_level != DEPTH)`.
  - A full FIFO refuses a push even if it is popped in the same cycle.
  - A push and a pop in the same cycle leave the level unchanged.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- **Pop.** A byte transfers to the emitter at a rising edge when `tx_valid && tx_ready`. The owner's FIFO pops on that edge.
- **State machine** (states IDLE, LOCKED) with registers `last` (1 bit, reset 1'b1) and `idle_cnt`:
  - IDLE: `grant` = 00 and `tx_valid` = 0.
    - If exactly one FIFO is non-empty, go to LOCKED with that port as owner.
    - If both are non-empty, the owner is `!last`, so port 0 wins first after reset.
  - LOCKED: `tx_valid = (owner level != 0)` and `tx_data` = owner FIFO head.
    - Release on transfer: if `LOCK_LINES`=0, or the transferred byte is 8'h0A, go to IDLE, set `last` ← owner and clear `idle_cnt`.
    - While the owner's FIFO is empty, `idle_cnt` increments; any non-empty cycle clears it.
    - Timeout: when `idle_cnt` reaches LOCK_TIMEOUT-1 and the FIFO is still empty, go to IDLE, set `last` ← owner and clear `idle_cnt`.
- The non-owner's FIFO continues to accept pushes while locked out.
- `tx_data` is don't-care when `tx_valid` = 0. The bench checks it only when `tx_valid` = 1.
- `tx_valid` and `tx_data` depend only on registered state and FIFO contents. There is no combinational path from `tx_ready`.
- **Reset.** Asserting `rst` at any time, including mid-line, immediately clears both FIFOs, the pointers, the state (IDLE), `last`=1 and `idle_cnt`=0. Buffered bytes are discarded.
  - Output reset values: `tx_valid`=0, `grant`=00, `p0_ready`=`p1_ready`=1, levels 0, `tx_data`=8'h00.

## Timing
- Write-to-offer latency from IDLE: a byte pushed at edge N raises the level after N. The grant is taken at edge N+1, and `tx_valid` is high after edge N+1 (two cycles).
- While locked with data available, bytes transfer back-to-back, one per cycle that `tx_ready` is high.
- A release costs exactly one IDLE cycle (`tx_valid`=0) before the next grant.
- The timeout releases after LOCK_TIMEOUT consecutive empty cycles.
- The `grant` change is visible the cycle after the deciding edge.

## Test plan
- **Single-port message.** After reset, push "Hi\n" (48 69 0A) on port 0 with `tx_ready` held at 1.
  - `tx_valid` rises 2 cycles after the first push.
  - Bytes 48, 69, 0A are emitted in order; `grant` goes 01→00.
  - `p0_level` returns to 0.
- **Line locking.** Fill port 0 with "AB\n" and port 1 with "xy\n" in the same cycle.
  - Output is 41 42 0A, then one idle cycle, then 78 79 0A.
  - The next contention goes to port 0 again only if port 1 released last.
- **Round-robin.** With `LOCK_LINES`=0 and both ports loaded, output alternates p0, p1, p0, p1…, with a bubble between bytes.
- **Backpressure and full.** Hold `tx_ready`=0 and push DEPTH+1 bytes on port 1.
  - `p1_ready` drops after DEPTH pushes and the extra byte is not accepted.
  - Toggle `tx_ready`: exactly DEPTH bytes emerge in order.
  - Also cover a push and a pop in the same cycle with the level unchanged, and pointer wrap.
- **Timeout.** Port 0 sends "ab" without 0A; port 1 holds "z\n".
  - Port 0 keeps `grant` for LOCK_TIMEOUT empty cycles, then `grant`=00 for one cycle.
  - Port 1 is then granted and 7A 0A are emitted.
- **Async reset mid-line.** Assert `rst` between edges while locked with 3 bytes buffered.
  - `tx_valid`, `grant` and the levels clear immediately, without waiting for a clock edge.
  - After release, behaviour matches fresh power-up.
